// File: rtl/tile_fragment_walker_if.sv
// Stream interfaces around tile_fragment_walker:
//   tile_setup_if - one tile setup per vld_in/rdy_in handshake (producer = master)
//   frag_if       - one fragment per vld_out/rdy_out handshake (producer = master)
// coord_3d_t fields are packed {x, y, z}, FXW bits each, x in the top bits.

interface tile_setup_if #(
  parameter int FXW = 16
);
  logic             vld_in;
  logic             rdy_in;
  logic [3*FXW-1:0] in_abs_pos;
  logic [3*FXW-1:0] in_delta_0;
  logic [3*FXW-1:0] in_delta_1;
  logic [3*FXW-1:0] in_delta_2;
  logic [2*FXW-1:0] in_edge_0;
  logic [2*FXW-1:0] in_edge_1;
  logic [2*FXW-1:0] in_edge_2;
  logic [3:0]       in_color;
  logic [FXW-1:0]   in_dzdx;
  logic [FXW-1:0]   in_dzdy;
  logic [2*FXW-1:0] in_z_current;

  modport master (
    output vld_in, in_abs_pos, in_delta_0, in_delta_1, in_delta_2,
           in_edge_0, in_edge_1, in_edge_2, in_color, in_dzdx, in_dzdy, in_z_current,
    input  rdy_in
  );

  modport slave (
    input  vld_in, in_abs_pos, in_delta_0, in_delta_1, in_delta_2,
           in_edge_0, in_edge_1, in_edge_2, in_color, in_dzdx, in_dzdy, in_z_current,
    output rdy_in
  );
endinterface

interface frag_if #(
  parameter int FXW = 16,
  parameter int FXF = 4
);
  logic                 vld_out;
  logic                 rdy_out;
  logic [FXW-FXF-1:0]   out_x;
  logic [FXW-FXF-1:0]   out_y;
  logic [2*FXW-1:0]     out_z;
  logic [3:0]           out_color;

  modport master (
    output vld_out, out_x, out_y, out_z, out_color,
    input  rdy_out
  );

  modport slave (
    input  vld_out, out_x, out_y, out_z, out_color,
    output rdy_out
  );
endinterface

// File: rtl/tile_fragment_walker.sv
// tile_fragment_walker: accepts one tile setup, walks the TILE_DIM x TILE_DIM tile
// row-major one pixel per cycle (edges and z stepped incrementally), and emits a
// fragment for every pixel whose three edge values are all non-negative.
// Optional feature macro: TILE_WALK_FRAG_CNT_EN adds frag_cnt / tile_done outputs.

module tile_fragment_walker #(
  parameter int FXW      = 16,
  parameter int FXF      = 4,
  parameter int TILE_DIM = 32
) (
  input  logic         clk,
  input  logic         rst,
  tile_setup_if.slave  setup,
  frag_if.master       frag
`ifdef TILE_WALK_FRAG_CNT_EN
  ,
  output logic [2*$clog2(TILE_DIM):0] frag_cnt,
  output logic                        tile_done
`endif
);

  localparam int EW = 2 * FXW;             // edge / z width
  localparam int IW = FXW - FXF;           // integer pixel coordinate width
  localparam int CW = $clog2(TILE_DIM);    // column / row counter width
  localparam logic [CW-1:0] LAST = CW'(TILE_DIM - 1);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;

  state_t state_q, state_d;

  // Walk state
  logic signed [EW-1:0] edge_q     [3];
  logic signed [EW-1:0] row_edge_q [3];
  logic signed [EW-1:0] step_x_q   [3];   // per-column edge step (from delta.y)
  logic signed [EW-1:0] step_y_q   [3];   // per-row edge step (from delta.x)
  logic signed [EW-1:0] z_q, row_z_q, z_step_x_q, z_step_y_q;
  logic [IW-1:0]        base_x_q, base_y_q;
  logic [3:0]           color_q;
  logic [CW-1:0]        col_q, row_q;

  // Fragment output slot
  logic                 vld_q;
  logic [IW-1:0]        out_x_q, out_y_q;
  logic [EW-1:0]        out_z_q;
  logic [3:0]           out_color_q;

  logic rdy_in, accept, slot_free, walk_step, covered, col_last, last_pixel;

  logic [FXW-1:0] dx_in   [3];
  logic [FXW-1:0] dy_in   [3];
  logic [EW-1:0]  edge_in [3];

  assign dx_in[0]   = setup.in_delta_0[3*FXW-1:2*FXW];
  assign dx_in[1]   = setup.in_delta_1[3*FXW-1:2*FXW];
  assign dx_in[2]   = setup.in_delta_2[3*FXW-1:2*FXW];
  assign dy_in[0]   = setup.in_delta_0[2*FXW-1:FXW];
  assign dy_in[1]   = setup.in_delta_1[2*FXW-1:FXW];
  assign dy_in[2]   = setup.in_delta_2[2*FXW-1:FXW];
  assign edge_in[0] = setup.in_edge_0;
  assign edge_in[1] = setup.in_edge_1;
  assign edge_in[2] = setup.in_edge_2;

  // z components of positions/deltas and the fractional origin bits play no part.
  logic unused_setup_bits;
  assign unused_setup_bits = ^{setup.in_abs_pos[FXW-1:0],
                               setup.in_abs_pos[2*FXW+FXF-1:2*FXW],
                               setup.in_abs_pos[FXW+FXF-1:FXW],
                               setup.in_delta_0[FXW-1:0],
                               setup.in_delta_1[FXW-1:0],
                               setup.in_delta_2[FXW-1:0]};

  // 12_4 slope -> sign-extended 2*FXW value with 2*FXF fraction bits.
  function automatic logic signed [EW-1:0] to_wide(input logic [FXW-1:0] v);
    return EW'(signed'(v)) <<< FXF;
  endfunction

  assign slot_free  = !vld_q || frag.rdy_out;
  assign accept     = rdy_in && setup.vld_in;
  assign walk_step  = (state_q == WALK) && slot_free;
  assign covered    = !edge_q[0][EW-1] && !edge_q[1][EW-1] && !edge_q[2][EW-1];
  assign col_last   = (col_q == LAST);
  assign last_pixel = col_last && (row_q == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake ready.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    rdy_in  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_in = 1'b1;
        if (setup.vld_in) state_d = WALK;
      end
      WALK:    if (walk_step && last_pixel) state_d = DRAIN;
      DRAIN:   if (slot_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Setup latch, pixel evaluation, incremental edge/z stepping and output slot.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        edge_q[i]     <= '0;
        row_edge_q[i] <= '0;
        step_x_q[i]   <= '0;
        step_y_q[i]   <= '0;
      end
      z_q         <= '0;
      row_z_q     <= '0;
      z_step_x_q  <= '0;
      z_step_y_q  <= '0;
      base_x_q    <= '0;
      base_y_q    <= '0;
      color_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      vld_q       <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_color_q <= '0;
    end else begin
      if (accept) begin
        col_q      <= '0;
        row_q      <= '0;
        base_x_q   <= setup.in_abs_pos[3*FXW-1:2*FXW+FXF];
        base_y_q   <= setup.in_abs_pos[2*FXW-1:FXW+FXF];
        color_q    <= setup.in_color;
        z_q        <= setup.in_z_current;
        row_z_q    <= setup.in_z_current;
        z_step_x_q <= to_wide(setup.in_dzdx);
        z_step_y_q <= to_wide(setup.in_dzdy);
        for (int i = 0; i < 3; i++) begin
          edge_q[i]     <= edge_in[i];
          row_edge_q[i] <= edge_in[i];
          step_x_q[i]   <= to_wide(dy_in[i]);
          step_y_q[i]   <= to_wide(dx_in[i]);
        end
      end

      if (walk_step) begin
        if (covered) begin
          vld_q       <= 1'b1;
          out_x_q     <= base_x_q + IW'(col_q);
          out_y_q     <= base_y_q + IW'(row_q);
          out_z_q     <= z_q;
          out_color_q <= color_q;
        end else begin
          vld_q <= 1'b0;
        end

        if (col_last) begin
          // Row wrap: restart from the saved row-start values stepped once in y.
          col_q   <= '0;
          row_q   <= row_q + CW'(1);
          z_q     <= row_z_q + z_step_y_q;
          row_z_q <= row_z_q + z_step_y_q;
          for (int i = 0; i < 3; i++) begin
            edge_q[i]     <= row_edge_q[i] + step_y_q[i];
            row_edge_q[i] <= row_edge_q[i] + step_y_q[i];
          end
        end else begin
          col_q <= col_q + CW'(1);
          z_q   <= z_q + z_step_x_q;
          for (int i = 0; i < 3; i++) edge_q[i] <= edge_q[i] + step_x_q[i];
        end
      end else if (frag.rdy_out) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign setup.rdy_in   = rdy_in;
  assign frag.vld_out   = vld_q;
  assign frag.out_x     = out_x_q;
  assign frag.out_y     = out_y_q;
  assign frag.out_z     = out_z_q;
  assign frag.out_color = out_color_q;

`ifdef TILE_WALK_FRAG_CNT_EN
  localparam int NW = 2 * CW + 1;

  // Count fragment handshakes per tile; pulse tile_done as the walker returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      frag_cnt  <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= (state_q == DRAIN) && (state_d == IDLE);
      if (accept)                     frag_cnt <= '0;
      else if (vld_q && frag.rdy_out) frag_cnt <= frag_cnt + NW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tile_fragment_walker.sv
// Self-checking bench for tile_fragment_walker: directed tiles plus randomized tiles,
// compared against a closed-form coverage/z model of the whole tile.
`timescale 1ns/1ps

module tb_tile_fragment_walker;

  localparam int FXW      = 16;
  localparam int FXF      = 4;
  localparam int TILE_DIM = 32;
  localparam int NPIX     = TILE_DIM * TILE_DIM;
  localparam int IW       = FXW - FXF;

  typedef struct packed {
    logic [FXW-1:0]         pos_x;
    logic [FXW-1:0]         pos_y;
    logic [2:0][FXW-1:0]    dx;
    logic [2:0][FXW-1:0]    dy;
    logic [2:0][2*FXW-1:0]  e;
    logic [3:0]             color;
    logic [FXW-1:0]         dzdx;
    logic [FXW-1:0]         dzdy;
    logic [2*FXW-1:0]       z;
  } tile_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks;
  int   failures;
  int   got_cnt;
  bit   stall;
  logic [63:0] exp_q [$];

  tile_setup_if #(.FXW(FXW))           setup_bus ();
  frag_if       #(.FXW(FXW), .FXF(FXF)) frag_bus ();

`ifdef TILE_WALK_FRAG_CNT_EN
  logic [10:0] frag_cnt;
  logic        tile_done;
`endif

  tile_fragment_walker #(.FXW(FXW), .FXF(FXF), .TILE_DIM(TILE_DIM)) dut (
    .clk   (clk),
    .rst   (rst),
    .setup (setup_bus),
    .frag  (frag_bus)
`ifdef TILE_WALK_FRAG_CNT_EN
    ,
    .frag_cnt  (frag_cnt),
    .tile_done (tile_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input logic [IW-1:0] x, input logic [IW-1:0] y,
                                       input logic [31:0] z, input logic [3:0] col);
    return {4'b0, x, y, z, col};
  endfunction

  // Whole-tile reference: each pixel's edges and z in closed form (origin + c*step_x + r*step_y).
  function automatic void build_expected(input tile_t t);
    exp_q.delete();
    for (int r = 0; r < TILE_DIM; r++) begin
      for (int c = 0; c < TILE_DIM; c++) begin
        bit            cov;
        int            ev;
        int            zv;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        cov = 1'b1;
        for (int i = 0; i < 3; i++) begin
          ev = int'(t.e[i]) + c * (int'($signed(t.dy[i])) * 16) + r * (int'($signed(t.dx[i])) * 16);
          if (ev < 0) cov = 1'b0;
        end
        if (cov) begin
          x  = IW'(int'(t.pos_x[FXW-1:FXF]) + c);
          y  = IW'(int'(t.pos_y[FXW-1:FXF]) + r);
          zv = int'(t.z) + c * (int'($signed(t.dzdx)) * 16) + r * (int'($signed(t.dzdy)) * 16);
          exp_q.push_back(pack(x, y, 32'(zv), t.color));
        end
      end
    end
  endfunction

  function automatic tile_t base_tile();
    tile_t t;
    t.pos_x = 16'(96 << 4);
    t.pos_y = 16'(64 << 4);
    for (int i = 0; i < 3; i++) begin
      t.dx[i] = '0;
      t.dy[i] = '0;
      t.e[i]  = 32'd1;
    end
    t.color = 4'hA;
    t.dzdx  = '0;
    t.dzdy  = '0;
    t.z     = 32'h100;
    return t;
  endfunction

  task automatic drive_junk();
    setup_bus.in_abs_pos   = {$urandom, $urandom};
    setup_bus.in_delta_0   = {$urandom, $urandom};
    setup_bus.in_delta_1   = {$urandom, $urandom};
    setup_bus.in_delta_2   = {$urandom, $urandom};
    setup_bus.in_edge_0    = $urandom;
    setup_bus.in_edge_1    = $urandom;
    setup_bus.in_edge_2    = $urandom;
    setup_bus.in_color     = 4'($urandom);
    setup_bus.in_dzdx      = 16'($urandom);
    setup_bus.in_dzdy      = 16'($urandom);
    setup_bus.in_z_current = $urandom;
  endtask

  // Drives one tile; abort_at >= 0 resets the DUT at that pixel instead of finishing.
  task automatic run_tile(input tile_t t, input bit stall_en, input int abort_at, output int got);
    int n;
    bit done;
    build_expected(t);
    stall   = stall_en;
    got_cnt = 0;
    done    = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (setup_bus.rdy_in) done = 1'b1;
    end
    check("idle_before_tile", 64'(done), 64'd1);
    setup_bus.in_abs_pos   = {t.pos_x, t.pos_y, 16'($urandom)};
    setup_bus.in_delta_0   = {t.dx[0], t.dy[0], 16'($urandom)};
    setup_bus.in_delta_1   = {t.dx[1], t.dy[1], 16'($urandom)};
    setup_bus.in_delta_2   = {t.dx[2], t.dy[2], 16'($urandom)};
    setup_bus.in_edge_0    = t.e[0];
    setup_bus.in_edge_1    = t.e[1];
    setup_bus.in_edge_2    = t.e[2];
    setup_bus.in_color     = t.color;
    setup_bus.in_dzdx      = t.dzdx;
    setup_bus.in_dzdy      = t.dzdy;
    setup_bus.in_z_current = t.z;
    setup_bus.vld_in       = 1'b1;
    n = cyc + 1;
    @(posedge clk);
    #1;
    setup_bus.vld_in = 1'b0;
    drive_junk();

    if (abort_at >= 0) begin
      do @(negedge clk); while (cyc < n + abort_at);
      rst = 1'b1;
      @(negedge clk);
      check("abort_vld_out", 64'(frag_bus.vld_out), 64'd0);
      check("abort_rdy_in",  64'(setup_bus.rdy_in), 64'd1);
      check("abort_out_z",   64'(frag_bus.out_z),   64'd0);
      check("abort_out_x",   64'(frag_bus.out_x),   64'd0);
`ifdef TILE_WALK_FRAG_CNT_EN
      check("abort_frag_cnt", 64'(frag_cnt), 64'd0);
`endif
      rst = 1'b0;
      exp_q.delete();
      got = got_cnt;
      return;
    end

    done = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      @(negedge clk);
      if (setup_bus.rdy_in) done = 1'b1;
    end
    check("tile_done_in_time", 64'(done), 64'd1);
    if (done && !stall_en) check("rdy_in_latency", 64'(cyc), 64'(n + NPIX + 1));
    check("leftover_frags", 64'(exp_q.size()), 64'd0);
    got = got_cnt;
`ifdef TILE_WALK_FRAG_CNT_EN
    check("tile_done_pulse", 64'(tile_done), 64'd1);
    check("frag_cnt_final",  64'(frag_cnt),  64'(got_cnt));
    @(negedge clk);
    check("tile_done_clear", 64'(tile_done), 64'd0);
    check("frag_cnt_held",   64'(frag_cnt),  64'(got_cnt));
`endif
  endtask

  // Downstream ready: always 1, or a fair coin while stall is set.
  initial begin
    frag_bus.rdy_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      frag_bus.rdy_out = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Fragment monitor: scoreboard on each handshake, stability while stalled.
  initial begin
    logic [63:0] cur;
    logic [63:0] held;
    bit          hold_valid;
    hold_valid = 1'b0;
    forever begin
      @(negedge clk);
      cur = pack(frag_bus.out_x, frag_bus.out_y, frag_bus.out_z, frag_bus.out_color);
      if (rst) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid) check("stall_hold", {cur[63:61], frag_bus.vld_out, cur[59:0]}, held);
        if (frag_bus.vld_out && frag_bus.rdy_out) begin
          check("frag_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check("frag", cur, exp_q.pop_front());
          got_cnt++;
          hold_valid = 1'b0;
        end else if (frag_bus.vld_out) begin
          held       = {cur[63:61], 1'b1, cur[59:0]};
          hold_valid = 1'b1;
        end else begin
          hold_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t t;
    int    got;
    checks   = 0;
    failures = 0;
    stall    = 1'b0;
    rst      = 1'b1;
    setup_bus.vld_in = 1'b0;
    drive_junk();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_in",    64'(setup_bus.rdy_in),   64'd1);
    check("rst_vld_out",   64'(frag_bus.vld_out),   64'd0);
    check("rst_out_x",     64'(frag_bus.out_x),     64'd0);
    check("rst_out_y",     64'(frag_bus.out_y),     64'd0);
    check("rst_out_z",     64'(frag_bus.out_z),     64'd0);
    check("rst_out_color", 64'(frag_bus.out_color), 64'd0);
    rst = 1'b0;

    // Full cover
    t = base_tile();
    run_tile(t, 1'b0, -1, got);
    check("full_cover_count", 64'(got), 64'd1024);

    // No cover
    t = base_tile();
    t.e[0] = 32'hFFFF_FFFF;
    run_tile(t, 1'b0, -1, got);
    check("no_cover_count", 64'(got), 64'd0);

    // Half plane: columns 0..15 only
    t = base_tile();
    t.e[0]  = 32'd240;
    t.dy[0] = 16'hFFFF;
    run_tile(t, 1'b0, -1, got);
    check("half_plane_count", 64'(got), 64'd512);

    // Z ramp
    t = base_tile();
    t.z    = '0;
    t.dzdx = 16'd1;
    t.dzdy = 16'd2;
    run_tile(t, 1'b0, -1, got);
    check("z_ramp_count", 64'(got), 64'd1024);

    // Backpressure on full cover
    t = base_tile();
    run_tile(t, 1'b1, -1, got);
    check("stall_count", 64'(got), 64'd1024);

    // Reset mid-walk, then recovery on the half-plane tile
    t = base_tile();
    run_tile(t, 1'b0, 300, got);
    t = base_tile();
    t.e[0]  = 32'd240;
    t.dy[0] = 16'hFFFF;
    run_tile(t, 1'b0, -1, got);
    check("after_reset_count", 64'(got), 64'd512);

    // Random tiles, random backpressure
    for (int k = 0; k < 4; k++) begin
      t.pos_x = 16'($urandom);
      t.pos_y = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
        t.e[i]  = 32'(int'($urandom_range(0, 12000)) - 4000);
        t.dx[i] = 16'(int'($urandom_range(0, 200)) - 100);
        t.dy[i] = 16'(int'($urandom_range(0, 200)) - 100);
      end
      t.color = 4'($urandom);
      t.dzdx  = 16'($urandom);
      t.dzdy  = 16'($urandom);
      t.z     = $urandom;
      run_tile(t, 1'($urandom_range(0, 1)), -1, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
